// File: rtl/walksat_step_sequencer.sv
// WalkSAT flip sequencer: issues the datapath control word for one
// pick/load/fetch/select/flip/update iteration per unsat clause visit.
module walksat_step_sequencer #(
  parameter int unsigned NSAT                    = 3,
  parameter int unsigned CONTROLLER_SIGNAL_WIDTH = 14,
  parameter int unsigned BREAK_WIDTH             = 5,
  parameter int unsigned FLIP_WIDTH              = 32,
  parameter int unsigned NOISE_WIDTH             = 8,
  parameter logic [15:0] LFSR_SEED               = 16'hACE1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic                               abort_i,
  input  logic [FLIP_WIDTH-1:0]              max_flips_i,
  input  logic [NOISE_WIDTH-1:0]             noise_i,
  input  logic                               ucb_empty_i,
  input  logic                               ucb_rd_valid_i,
  input  logic                               break_valid_i,
  input  logic [BREAK_WIDTH-1:0]             break_count_i,
  input  logic                               update_done_i,
  output logic [CONTROLLER_SIGNAL_WIDTH-1:0] control_signal_o,
  output logic [1:0]                         lit_idx_o,
  output logic [FLIP_WIDTH-1:0]              flip_count_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               sat_o
);

  localparam int unsigned NSLOT    = 4;
  localparam logic [1:0]  LAST_IDX = 2'(NSAT - 1);
  localparam logic [2:0]  NSAT_W   = 3'(NSAT);

  localparam logic [1:0] UCB_NONE   = 2'b00;
  localparam logic [1:0] UCB_READ   = 2'b01;
  localparam logic [1:0] UCB_UPDATE = 2'b10;

  localparam logic [1:0] PICK_NONE    = 2'b00;
  localparam logic [1:0] PICK_FREEBIE = 2'b01;
  localparam logic [1:0] PICK_GREEDY  = 2'b10;
  localparam logic [1:0] PICK_WALK    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_LOAD, S_FETCH, S_SELECT, S_FLIP, S_UPDATE, S_DONE
  } state_t;

  state_t                               state_q, state_d;
  logic [FLIP_WIDTH-1:0]                max_q, max_d;
  logic [NOISE_WIDTH-1:0]               noise_q, noise_d;
  logic [15:0]                          lfsr_q, lfsr_d;
  logic [BREAK_WIDTH-1:0]               brk_q [NSLOT];
  logic [BREAK_WIDTH-1:0]               brk_d [NSLOT];
  logic [1:0]                           lit_d;
  logic [FLIP_WIDTH-1:0]                flip_d;
  logic                                 sat_d;
  logic [1:0]                           mode_d;
  logic [CONTROLLER_SIGNAL_WIDTH-1:0]   ctrl_d;

  logic                                 free_hit;
  logic [1:0]                           free_idx;
  logic [1:0]                           min_idx;
  logic [BREAK_WIDTH-1:0]               min_val;
  logic [1:0]                           walk_idx;
  logic [1:0]                           sel_idx;
  logic [1:0]                           sel_mode;
  logic                                 busy_state;

  // Break-count capture; abort suppresses the write so a killed fetch leaves no trace.
  always_comb begin
    brk_d = brk_q;
    if (state_q == S_FETCH && break_valid_i && !abort_i)
      brk_d[lit_idx_o] = break_count_i;
  end

  // Variable selection over the break counts as they will stand after this cycle.
  always_comb begin
    free_hit = 1'b0;
    free_idx = 2'b00;
    for (int i = int'(NSAT) - 1; i >= 0; i--) begin
      if (brk_d[2'(i)] == '0) begin
        free_hit = 1'b1;
        free_idx = 2'(i);
      end
    end
    min_idx = 2'b00;
    min_val = brk_d[0];
    for (int i = 1; i < int'(NSAT); i++) begin
      if (brk_d[2'(i)] < min_val) begin
        min_idx = 2'(i);
        min_val = brk_d[2'(i)];
      end
    end
    walk_idx = ({1'b0, lfsr_q[9:8]} >= NSAT_W) ? 2'b00 : lfsr_q[9:8];
    if (free_hit) begin
      sel_idx  = free_idx;
      sel_mode = PICK_FREEBIE;
    end else if (NOISE_WIDTH'(lfsr_q[7:0]) < noise_q) begin
      sel_idx  = walk_idx;
      sel_mode = PICK_WALK;
    end else begin
      sel_idx  = min_idx;
      sel_mode = PICK_GREEDY;
    end
  end

  assign busy_state = (state_q != S_IDLE) && (state_q != S_DONE);

  // Next-state, next-output and control word generation.
  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    noise_d = noise_q;
    lfsr_d  = lfsr_q;
    lit_d   = lit_idx_o;
    flip_d  = flip_count_o;
    sat_d   = sat_o;
    mode_d  = PICK_NONE;
    ctrl_d  = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          max_d   = max_flips_i;
          noise_d = noise_i;
          flip_d  = '0;
          lit_d   = 2'b00;
          sat_d   = 1'b0;
          if (max_flips_i == '0) begin
            state_d = S_DONE;
            sat_d   = ucb_empty_i;
          end else begin
            state_d = S_PICK;
          end
        end
      end
      S_PICK: begin
        if (ucb_empty_i) begin
          state_d = S_DONE;
          sat_d   = 1'b1;
        end else if (ucb_rd_valid_i) begin
          state_d = S_LOAD;
          lit_d   = 2'b00;
        end
      end
      S_LOAD: begin
        state_d = S_FETCH;
        lit_d   = 2'b00;
      end
      S_FETCH: begin
        if (break_valid_i) begin
          if (lit_idx_o == LAST_IDX) begin
            state_d = S_SELECT;
            lit_d   = sel_idx;
            mode_d  = sel_mode;
            lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
          end else begin
            lit_d = lit_idx_o + 2'd1;
          end
        end
      end
      S_SELECT: begin
        state_d = S_FLIP;
        if (flip_count_o != '1)
          flip_d = flip_count_o + FLIP_WIDTH'(1);
      end
      S_FLIP: state_d = S_UPDATE;
      S_UPDATE: begin
        if (update_done_i) begin
          if (flip_count_o == max_q) begin
            state_d = S_DONE;
            sat_d   = 1'b0;
          end else begin
            state_d = S_PICK;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the iteration was about to do, including a flip.
    if (abort_i && busy_state) begin
      state_d = S_DONE;
      sat_d   = 1'b0;
      lit_d   = lit_idx_o;
      flip_d  = flip_count_o;
      lfsr_d  = lfsr_q;
      mode_d  = PICK_NONE;
    end

    case (state_d)
      S_PICK: begin
        ctrl_d[11:10] = UCB_READ;
        ctrl_d[1]     = 1'b1;
      end
      S_LOAD: begin
        ctrl_d[9] = 1'b1;
        ctrl_d[0] = 1'b1;
      end
      S_FETCH:  ctrl_d[8] = 1'b1;
      S_SELECT: ctrl_d[3:2] = mode_d;
      S_FLIP: begin
        ctrl_d[8] = 1'b1;
        ctrl_d[7] = 1'b1;
        ctrl_d[4] = 1'b1;
      end
      S_UPDATE: ctrl_d[11:10] = UCB_UPDATE;
      default:  ctrl_d = '0;
    endcase
    if (state_d != S_IDLE && state_d != S_DONE) begin
      ctrl_d[6:5]   = lit_d;
      ctrl_d[13:12] = 2'b00;
    end
    if (state_d == S_LOAD || state_d == S_FETCH || state_d == S_SELECT
        || state_d == S_FLIP) begin
      ctrl_d[11:10] = (state_d == S_LOAD || state_d == S_FETCH) ? UCB_NONE : ctrl_d[11:10];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q          <= S_IDLE;
      max_q            <= '0;
      noise_q          <= '0;
      lfsr_q           <= LFSR_SEED;
      for (int i = 0; i < int'(NSLOT); i++) brk_q[i] <= '0;
      control_signal_o <= '0;
      lit_idx_o        <= 2'b00;
      flip_count_o     <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      sat_o            <= 1'b0;
    end else begin
      state_q          <= state_d;
      max_q            <= max_d;
      noise_q          <= noise_d;
      lfsr_q           <= lfsr_d;
      brk_q            <= brk_d;
      control_signal_o <= ctrl_d;
      lit_idx_o        <= lit_d;
      flip_count_o     <= flip_d;
      busy_o           <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_o           <= (state_d == S_DONE);
      sat_o            <= sat_d;
    end
  end

endmodule

// File: tb/tb_walksat_step_sequencer.sv
// Directed bench for walksat_step_sequencer: reset, empty buffer, freebie,
// greedy, walk, timeout, abort and mid-operation reset scenarios.
module tb_walksat_step_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        abort_i;
  logic [31:0] max_flips_i;
  logic [7:0]  noise_i;
  logic        ucb_empty_i;
  logic        ucb_rd_valid_i;
  logic        break_valid_i;
  logic [4:0]  break_count_i;
  logic        update_done_i;
  logic [13:0] control_signal_o;
  logic [1:0]  lit_idx_o;
  logic [31:0] flip_count_o;
  logic        busy_o;
  logic        done_o;
  logic        sat_o;

  logic [4:0]  brk_tb [4];
  int          total = 0;
  int          bad   = 0;

  walksat_step_sequencer dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .max_flips_i      (max_flips_i),
    .noise_i          (noise_i),
    .ucb_empty_i      (ucb_empty_i),
    .ucb_rd_valid_i   (ucb_rd_valid_i),
    .break_valid_i    (break_valid_i),
    .break_count_i    (break_count_i),
    .update_done_i    (update_done_i),
    .control_signal_o (control_signal_o),
    .lit_idx_o        (lit_idx_o),
    .flip_count_o     (flip_count_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .sat_o            (sat_o)
  );

  always #5 clk_i = ~clk_i;

  // Variable-table stand-in: answers the addressed literal's break count.
  always_comb break_count_i = brk_tb[lit_idx_o];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    #7;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  // Start pulse then advance until the SELECT cycle is visible.
  task automatic start_to_select(input logic [31:0] mx, input logic [7:0] nz);
    max_flips_i = mx;
    noise_i     = nz;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; max_flips_i = 32'd0; noise_i = 8'd0;
    ucb_empty_i = 1'b0; ucb_rd_valid_i = 1'b1; break_valid_i = 1'b1; update_done_i = 1'b1;
    brk_tb[0] = 5'd0; brk_tb[1] = 5'd0; brk_tb[2] = 5'd0; brk_tb[3] = 5'd0;
    #12;
    total++;
    if ({control_signal_o, lit_idx_o, flip_count_o, busy_o, done_o, sat_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ctrl=%h lit=%0d flips=%0d busy=%b done=%b sat=%b want all 0",
               control_signal_o, lit_idx_o, flip_count_o, busy_o, done_o, sat_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_empty();
    ucb_empty_i = 1'b1;
    max_flips_i = 32'd5;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    total++;
    if (control_signal_o !== 14'h0402 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL empty_pick_word: got ctrl=%h busy=%b want 0402 busy=1", control_signal_o, busy_o);
    end
    tick();
    total++;
    if (done_o !== 1'b1 || sat_o !== 1'b1 || flip_count_o !== 32'd0 || busy_o !== 1'b0
        || control_signal_o !== 14'h0) begin
      bad++;
      $display("FAIL empty_done: got done=%b sat=%b flips=%0d busy=%b ctrl=%h want 1 1 0 0 0000",
               done_o, sat_o, flip_count_o, busy_o, control_signal_o);
    end
    ucb_empty_i = 1'b0;
  endtask

  task automatic test_zero_flips();
    max_flips_i = 32'd0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    total++;
    if (done_o !== 1'b1 || sat_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL zero_flips: got done=%b sat=%b busy=%b want 1 0 0", done_o, sat_o, busy_o);
    end
  endtask

  task automatic test_freebie();
    brk_tb[0] = 5'd3; brk_tb[1] = 5'd0; brk_tb[2] = 5'd2;
    max_flips_i = 32'd1; noise_i = 8'd0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    total++;
    if (control_signal_o !== 14'h0402) begin
      bad++; $display("FAIL freebie_pick: got %h want 0402", control_signal_o);
    end
    tick();
    total++;
    if (control_signal_o !== 14'h0201 || lit_idx_o !== 2'd0) begin
      bad++; $display("FAIL freebie_load: got ctrl=%h lit=%0d want 0201 0", control_signal_o, lit_idx_o);
    end
    tick();
    total++;
    if (control_signal_o !== 14'h0100) begin
      bad++; $display("FAIL freebie_fetch0: got %h want 0100", control_signal_o);
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    total++;
    if (control_signal_o !== 14'h0120 || lit_idx_o !== 2'd1) begin
      bad++; $display("FAIL freebie_fetch1: got ctrl=%h lit=%0d want 0120 1", control_signal_o, lit_idx_o);
    end
    tick();
    total++;
    if (control_signal_o !== 14'h0140) begin
      bad++; $display("FAIL freebie_fetch2: got %h want 0140", control_signal_o);
    end
    tick();
    total++;
    if (control_signal_o !== 14'h0024 || lit_idx_o !== 2'd1) begin
      bad++; $display("FAIL freebie_select: got ctrl=%h lit=%0d want 0024 1", control_signal_o, lit_idx_o);
    end
    tick();
    total++;
    if (control_signal_o !== 14'h01B0 || flip_count_o !== 32'd1) begin
      bad++; $display("FAIL freebie_flip: got ctrl=%h flips=%0d want 01b0 1", control_signal_o, flip_count_o);
    end
    tick();
    total++;
    if (control_signal_o !== 14'h0820) begin
      bad++; $display("FAIL freebie_update: got %h want 0820", control_signal_o);
    end
    tick();
    total++;
    if (done_o !== 1'b1 || sat_o !== 1'b0 || control_signal_o !== 14'h0) begin
      bad++; $display("FAIL freebie_done: got done=%b sat=%b ctrl=%h want 1 0 0000", done_o, sat_o, control_signal_o);
    end
    tick();
    total++;
    if (done_o !== 1'b1 || flip_count_o !== 32'd1 || lit_idx_o !== 2'd1) begin
      bad++; $display("FAIL done_hold: got done=%b flips=%0d lit=%0d want 1 1 1", done_o, flip_count_o, lit_idx_o);
    end
  endtask

  task automatic test_greedy_tie();
    brk_tb[0] = 5'd4; brk_tb[1] = 5'd2; brk_tb[2] = 5'd2;
    start_to_select(32'd1, 8'd0);
    total++;
    if (control_signal_o !== 14'h0028 || lit_idx_o !== 2'd1) begin
      bad++; $display("FAIL greedy_select: got ctrl=%h lit=%0d want 0028 1", control_signal_o, lit_idx_o);
    end
    repeat (3) tick();
    total++;
    if (done_o !== 1'b1 || flip_count_o !== 32'd1) begin
      bad++; $display("FAIL greedy_done: got done=%b flips=%0d want 1 1", done_o, flip_count_o);
    end
  endtask

  task automatic test_walk();
    logic [15:0] m;
    logic [1:0]  r;
    logic [1:0]  exp_idx;
    logic [1:0]  exp_mode;
    do_reset();
    m = 16'hACE1;
    brk_tb[0] = 5'd5; brk_tb[1] = 5'd5; brk_tb[2] = 5'd5;
    start_to_select(32'd2, 8'd255);
    for (int it = 0; it < 2; it++) begin
      r        = m[9:8];
      exp_idx  = (r >= 2'd3) ? 2'd0 : r;
      exp_mode = (m[7:0] < 8'd255) ? 2'b11 : 2'b10;
      total++;
      if (control_signal_o !== {7'd0, exp_idx, 1'b0, exp_mode, 2'b00} || lit_idx_o !== exp_idx) begin
        bad++;
        $display("FAIL walk_select%0d: got ctrl=%h lit=%0d want ctrl=%h lit=%0d", it,
                 control_signal_o, lit_idx_o, {7'd0, exp_idx, 1'b0, exp_mode, 2'b00}, exp_idx);
      end
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
      if (it == 0) repeat (8) tick();
    end
    repeat (3) tick();
    total++;
    if (done_o !== 1'b1 || flip_count_o !== 32'd2 || sat_o !== 1'b0) begin
      bad++; $display("FAIL walk_done: got done=%b flips=%0d sat=%b want 1 2 0", done_o, flip_count_o, sat_o);
    end
  endtask

  task automatic test_timeout();
    int  busy_cnt;
    int  flips;
    int  wr;
    bit  fin;
    busy_cnt = 0; flips = 0; wr = 0; fin = 1'b0;
    brk_tb[0] = 5'd1; brk_tb[1] = 5'd1; brk_tb[2] = 5'd1;
    max_flips_i = 32'd3; noise_i = 8'd0;
    start_i = 1'b1;
    for (int c = 0; c < 100 && !fin; c++) begin
      tick();
      start_i = 1'b0;
      if (busy_o) busy_cnt++;
      if (control_signal_o[4]) flips++;
      if (control_signal_o[7]) wr++;
      if (done_o) fin = 1'b1;
    end
    total++;
    if (!fin) begin
      bad++; $display("FAIL timeout_bound: done never seen within 100 cycles, want done");
    end
    total++;
    if (busy_cnt != 24 || flips != 3 || wr != 3) begin
      bad++; $display("FAIL timeout_counts: got busy=%0d flips=%0d wr=%0d want 24 3 3", busy_cnt, flips, wr);
    end
    total++;
    if (sat_o !== 1'b0 || flip_count_o !== 32'd3) begin
      bad++; $display("FAIL timeout_result: got sat=%b flips=%0d want 0 3", sat_o, flip_count_o);
    end
  endtask

  task automatic test_abort();
    int wr;
    wr = 0;
    brk_tb[0] = 5'd2; brk_tb[1] = 5'd2; brk_tb[2] = 5'd2;
    max_flips_i = 32'd4; noise_i = 8'd0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (2) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    total++;
    if (done_o !== 1'b1 || sat_o !== 1'b0 || busy_o !== 1'b0 || control_signal_o !== 14'h0) begin
      bad++; $display("FAIL abort_fetch: got done=%b sat=%b busy=%b ctrl=%h want 1 0 0 0000",
                      done_o, sat_o, busy_o, control_signal_o);
    end
    repeat (3) begin
      tick();
      if (control_signal_o[7]) wr++;
    end
    total++;
    if (wr != 0 || done_o !== 1'b1) begin
      bad++; $display("FAIL abort_no_write: got wr=%0d done=%b want 0 1", wr, done_o);
    end
    start_to_select(32'd4, 8'd0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    total++;
    if (done_o !== 1'b1 || flip_count_o !== 32'd0 || control_signal_o !== 14'h0 || sat_o !== 1'b0) begin
      bad++; $display("FAIL abort_select: got done=%b flips=%0d ctrl=%h sat=%b want 1 0 0000 0",
                      done_o, flip_count_o, control_signal_o, sat_o);
    end
  endtask

  task automatic test_reset_mid();
    brk_tb[0] = 5'd2; brk_tb[1] = 5'd2; brk_tb[2] = 5'd2;
    update_done_i = 1'b0;
    start_to_select(32'd4, 8'd0);
    repeat (3) tick();
    total++;
    if (control_signal_o !== 14'h0800 || flip_count_o !== 32'd1) begin
      bad++; $display("FAIL update_hold: got ctrl=%h flips=%0d want 0800 1", control_signal_o, flip_count_o);
    end
    #2;
    rst_i = 1'b0;
    #1;
    total++;
    if (control_signal_o !== 14'h0 || busy_o !== 1'b0 || flip_count_o !== 32'd0 || done_o !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got ctrl=%h busy=%b flips=%0d done=%b want 0000 0 0 0",
                      control_signal_o, busy_o, flip_count_o, done_o);
    end
    update_done_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_empty();
    test_zero_flips();
    test_freebie();
    test_greedy_tie();
    test_walk();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
